// File: rtl/sound_pkg.sv
// Shared constants and types for the main-CPU to sound-CPU command path.
// SND_VEC_* describe the IM0 vector byte: idle is RST 38h (0xFF); each active
// request source clears its own bit, so the sound CPU lands on a distinct RST.
package sound_pkg;

    localparam logic [7:0] SND_VEC_IDLE    = 8'hFF;
    localparam int         SND_VEC_YM_BIT  = 4;
    localparam int         SND_VEC_CMD_BIT = 5;

    typedef logic [7:0] snd_cmd_t;

    // Vector byte for the given pair of request levels.
    function automatic snd_cmd_t snd_vector(input logic ym_req, input logic cmd_req);
        snd_cmd_t v;
        v = SND_VEC_IDLE;
        if (ym_req)  v[SND_VEC_YM_BIT]  = 1'b0;
        if (cmd_req) v[SND_VEC_CMD_BIT] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Generic synchronous FIFO with a registered head output.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   push      write din (accepted when not full, or when a pop frees a slot)
//   pop       remove head entry (ignored when empty)
//   din       write data
//   dout      registered head entry, zero when empty
//   full      DEPTH entries held
//   empty     no entries held
//   drop      push refused this cycle because the FIFO stayed full
module sound_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign dout  = dout_q;

    always_comb begin
        pop_ok   = pop & ~empty;
        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        push_ok  = push & (~full | pop_ok);
        drop     = push & ~push_ok;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Next head: the incoming byte when it is written into the new head slot
        // (push into empty, or push+pop leaving only that byte), otherwise storage.
        dout_d = '0;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) dout_d = din;
            else                                   dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= din;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/sound_cmd_latch.sv
// Command path from the main CPU to the sound CPU plus the merged IM0 interrupt.
// Ports:
//   CLK_32M     system clock
//   RESET       asynchronous active-high reset
//   MAIN_DIN    command byte from the main CPU
//   MAIN_WR     one-cycle push strobe
//   MAIN_FULL   command FIFO full
//   OVERFLOW    sticky: a command was dropped while full
//   Z80_DOUT    head command byte (0x00 when empty)
//   Z80_ACK     one-cycle pop strobe from the sound CPU
//   YM_IRQ_N    YM2151 interrupt, active low, asynchronous
//   Z80_INT_N   sound CPU interrupt, active low
//   Z80_VECTOR  IM0 vector byte
module sound_cmd_latch
    import sound_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK_32M,
    input  logic       RESET,
    input  logic [7:0] MAIN_DIN,
    input  logic       MAIN_WR,
    output logic       MAIN_FULL,
    output logic       OVERFLOW,
    output logic [7:0] Z80_DOUT,
    input  logic       Z80_ACK,
    input  logic       YM_IRQ_N,
    output logic       Z80_INT_N,
    output logic [7:0] Z80_VECTOR
);

    logic                   fifo_empty, fifo_drop;
    snd_cmd_t               fifo_dout;
    logic [SYNC_STAGES-1:0] ym_sync_q;
    logic                   ym_req, pop_ok;
    logic                   cmd_req_q, cmd_req_d;
    logic                   overflow_q, overflow_d;
    logic                   int_n_q, int_n_d;
    snd_cmd_t               vector_q, vector_d;

    sound_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK_32M),
        .rst   (RESET),
        .push  (MAIN_WR),
        .pop   (Z80_ACK),
        .din   (MAIN_DIN),
        .dout  (fifo_dout),
        .full  (MAIN_FULL),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    always_comb begin
        pop_ok     = Z80_ACK & ~fifo_empty;
        ym_req     = ~ym_sync_q[SYNC_STAGES-1];
        // Ack drops the request for one cycle; any remaining entry re-raises it,
        // so every command gives the sound CPU its own interrupt edge.
        cmd_req_d  = ~pop_ok & (MAIN_WR | ~fifo_empty);
        overflow_d = overflow_q | fifo_drop;
        vector_d   = snd_vector(ym_req, cmd_req_q);
        int_n_d    = ~(ym_req | cmd_req_q);
    end

    always_ff @(posedge CLK_32M or posedge RESET) begin
        if (RESET) begin
            ym_sync_q  <= '1;
            cmd_req_q  <= 1'b0;
            overflow_q <= 1'b0;
            int_n_q    <= 1'b1;
            vector_q   <= SND_VEC_IDLE;
        end else begin
            ym_sync_q[0] <= YM_IRQ_N;
            for (int i = 1; i < SYNC_STAGES; i++) ym_sync_q[i] <= ym_sync_q[i-1];
            cmd_req_q  <= cmd_req_d;
            overflow_q <= overflow_d;
            int_n_q    <= int_n_d;
            vector_q   <= vector_d;
        end
    end

    assign OVERFLOW   = overflow_q;
    assign Z80_DOUT   = fifo_dout;
    assign Z80_INT_N  = int_n_q;
    assign Z80_VECTOR = vector_q;

endmodule

// File: tb/tb_sound_cmd_latch.sv
module tb_sound_cmd_latch;

    logic       CLK_32M = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] MAIN_DIN = 8'h00;
    logic       MAIN_WR = 1'b0;
    logic       MAIN_FULL, OVERFLOW;
    logic [7:0] Z80_DOUT;
    logic       Z80_ACK = 1'b0;
    logic       YM_IRQ_N = 1'b1;
    logic       Z80_INT_N;
    logic [7:0] Z80_VECTOR;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];   // expected FIFO contents, head first

    sound_cmd_latch #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK_32M    (CLK_32M),
        .RESET      (RESET),
        .MAIN_DIN   (MAIN_DIN),
        .MAIN_WR    (MAIN_WR),
        .MAIN_FULL  (MAIN_FULL),
        .OVERFLOW   (OVERFLOW),
        .Z80_DOUT   (Z80_DOUT),
        .Z80_ACK    (Z80_ACK),
        .YM_IRQ_N   (YM_IRQ_N),
        .Z80_INT_N  (Z80_INT_N),
        .Z80_VECTOR (Z80_VECTOR)
    );

    always #5 CLK_32M = ~CLK_32M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges; returns 1 time unit after the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK_32M);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc(2);
        RESET = 1'b0;
        sb.delete();
        cyc(1);
    endtask

    task automatic push_cmd(input logic [7:0] b);
        MAIN_DIN = b;
        MAIN_WR  = 1'b1;
        if (sb.size() < 4) sb.push_back(b);
        cyc(1);
        MAIN_WR = 1'b0;
    endtask

    task automatic wait_int_low(input string tag);
        for (int i = 0; i < 20 && Z80_INT_N !== 1'b0; i++) cyc(1);
        check(tag, Z80_INT_N, 1'b0);
    endtask

    // Pop every expected entry: head must match the scoreboard, and INT_N must
    // go high for a cycle after each ack (YM must be idle here).
    task automatic drain(input string tag);
        logic [7:0] exp;
        while (sb.size() > 0) begin
            wait_int_low({tag, "_int"});
            exp = sb.pop_front();
            check({tag, "_dout"}, Z80_DOUT, exp);
            Z80_ACK = 1'b1;
            cyc(1);
            Z80_ACK = 1'b0;
            cyc(1);
            check({tag, "_pulse"}, Z80_INT_N, 1'b1);
        end
        check({tag, "_empty_dout"}, Z80_DOUT, 8'h00);
        check({tag, "_empty_full"}, MAIN_FULL, 1'b0);
    endtask

    initial begin
        // reset values
        cyc(2);
        check("rst_int", Z80_INT_N, 1'b1);
        check("rst_vec", Z80_VECTOR, 8'hFF);
        check("rst_dout", Z80_DOUT, 8'h00);
        check("rst_full", MAIN_FULL, 1'b0);
        check("rst_ovf", OVERFLOW, 1'b0);
        RESET = 1'b0;
        cyc(1);

        // 1: single command, latency and ack
        MAIN_DIN = 8'h5A;
        MAIN_WR  = 1'b1;
        sb.push_back(8'h5A);
        cyc(1);
        MAIN_WR = 1'b0;
        check("t1_int_e1", Z80_INT_N, 1'b1);
        check("t1_dout", Z80_DOUT, 8'h5A);
        cyc(1);
        check("t1_int_e2", Z80_INT_N, 1'b0);
        check("t1_vec", Z80_VECTOR, 8'hDF);
        void'(sb.pop_front());
        Z80_ACK = 1'b1;
        cyc(1);
        Z80_ACK = 1'b0;
        check("t1_dout_ack", Z80_DOUT, 8'h00);
        cyc(1);
        check("t1_int_rel", Z80_INT_N, 1'b1);
        check("t1_vec_rel", Z80_VECTOR, 8'hFF);

        // 2: fill, overflow, ordered drain
        push_cmd(8'h11);
        push_cmd(8'h22);
        push_cmd(8'h33);
        check("t2_full3", MAIN_FULL, 1'b0);
        push_cmd(8'h44);
        check("t2_full4", MAIN_FULL, 1'b1);
        check("t2_ovf0", OVERFLOW, 1'b0);
        push_cmd(8'h55);
        check("t2_ovf1", OVERFLOW, 1'b1);
        check("t2_head", Z80_DOUT, 8'h11);
        drain("t2");
        check("t2_ovf_sticky", OVERFLOW, 1'b1);

        // 3: simultaneous push and pop on a full FIFO
        do_reset();
        check("t3_ovf_rst", OVERFLOW, 1'b0);
        push_cmd(8'hA1);
        push_cmd(8'hA2);
        push_cmd(8'hA3);
        push_cmd(8'hA4);
        MAIN_DIN = 8'h66;
        MAIN_WR  = 1'b1;
        Z80_ACK  = 1'b1;
        void'(sb.pop_front());
        sb.push_back(8'h66);
        cyc(1);
        MAIN_WR = 1'b0;
        Z80_ACK = 1'b0;
        check("t3_full", MAIN_FULL, 1'b1);
        check("t3_ovf", OVERFLOW, 1'b0);
        check("t3_head", Z80_DOUT, 8'hA2);
        drain("t3");

        // 4: YM interrupt merging
        YM_IRQ_N = 1'b0;
        cyc(2);
        check("t4_int_e2", Z80_INT_N, 1'b1);
        cyc(1);
        check("t4_int_e3", Z80_INT_N, 1'b0);
        check("t4_vec_ym", Z80_VECTOR, 8'hEF);
        push_cmd(8'h77);
        cyc(1);
        check("t4_vec_both", Z80_VECTOR, 8'hCF);
        YM_IRQ_N = 1'b1;
        cyc(3);
        check("t4_vec_cmd", Z80_VECTOR, 8'hDF);
        drain("t4");
        check("t4_vec_idle", Z80_VECTOR, 8'hFF);

        // 5: ack on empty
        Z80_ACK = 1'b1;
        cyc(1);
        Z80_ACK = 1'b0;
        check("t5_dout", Z80_DOUT, 8'h00);
        cyc(2);
        check("t5_int", Z80_INT_N, 1'b1);
        push_cmd(8'h12);
        check("t5_push_dout", Z80_DOUT, 8'h12);
        drain("t5");

        // 6: asynchronous reset mid-stream
        push_cmd(8'h31);
        push_cmd(8'h32);
        YM_IRQ_N = 1'b0;
        cyc(4);
        check("t6_pre_int", Z80_INT_N, 1'b0);
        check("t6_pre_vec", Z80_VECTOR, 8'hCF);
        RESET = 1'b1;
        #2;
        check("t6_int", Z80_INT_N, 1'b1);
        check("t6_vec", Z80_VECTOR, 8'hFF);
        check("t6_dout", Z80_DOUT, 8'h00);
        check("t6_full", MAIN_FULL, 1'b0);
        check("t6_ovf", OVERFLOW, 1'b0);
        YM_IRQ_N = 1'b1;
        cyc(1);
        RESET = 1'b0;
        sb.delete();
        cyc(1);
        check("t6_post_dout", Z80_DOUT, 8'h00);
        push_cmd(8'h9C);
        check("t6_push_dout", Z80_DOUT, 8'h9C);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
